multiplier_controller: RTL and testbench

Sequencing stage placed directly upstream of `multiplier_datapath`. It accepts an operand pair over a start/ready handshake and registers the operands onto the datapath's `multiplicand`/`multiplier` inputs. It pulses `do_init` for one cycle, then holds `do_shift` high for exactly N cycles. It then raises `done` and holds it, and the datapath's `product`, until the consumer acknowledges.

---
 rtl/multiplier_controller.sv | 95 +++++++++
 tb/tb_multiplier_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multiplier_controller.sv
// Sequencer for the shift-add multiplier datapath: captures an operand pair,
// strobes a one-cycle load, N shift-add steps, then holds done until ack.
module multiplier_controller #(
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         ready,
  output logic [N-1:0] multiplicand,
  output logic [N-1:0] multiplier,
  output logic         do_init,
  output logic         do_shift,
  output logic         done,
  input  logic         ack
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic          accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operands only change on an accepted start, so the datapath sees stable
  // inputs for the whole operation regardless of upstream activity.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      multiplicand <= '0;
      multiplier   <= '0;
    end else if (accept) begin
      multiplicand <= a_in;
      multiplier   <= b_in;
    end
  end

  // Counter saturates at LAST so it never wraps, even when N is a power of two.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      count <= '0;
    end else begin
      case (state)
        INIT:    count <= '0;
        SHIFT:   if (count != LAST) count <= count + 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)          next_state = INIT;
      INIT:                        next_state = SHIFT;
      SHIFT:   if (count == LAST)  next_state = DONE;
      DONE:    if (ack)            next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    do_init  = 1'b0;
    do_shift = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    ready    = 1'b1;
      INIT:    do_init  = 1'b1;
      SHIFT:   do_shift = 1'b1;
      DONE:    done     = 1'b1;
      default: ready    = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multiplier_controller.sv
// Bench for multiplier_controller driving a behavioural shift-add datapath;
// expectations come from plain arithmetic and the cycle-level protocol.
module tb_multiplier_controller;

  localparam int unsigned N = 4;

  logic         clock = 1'b0;
  logic         n_reset;
  logic         start;
  logic         ack;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         ready;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic         do_init;
  logic         do_shift;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  multiplier_controller #(.N(N)) dut (
    .clock        (clock),
    .n_reset      (n_reset),
    .start        (start),
    .a_in         (a_in),
    .b_in         (b_in),
    .ready        (ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .do_init      (do_init),
    .do_shift     (do_shift),
    .done         (done),
    .ack          (ack)
  );

  always #5 clock = ~clock;

  // Stand-in datapath: load on do_init, one shift-add step per do_shift cycle.
  logic [2*N-1:0] product;
  logic [2*N-1:0] mc_ext;
  logic [N-1:0]   mp_r;

  always @(posedge clock) begin
    if (do_init) begin
      product <= '0;
      mc_ext  <= {{N{1'b0}}, multiplicand};
      mp_r    <= multiplier;
    end else if (do_shift) begin
      if (mp_r[0]) product <= product + mc_ext;
      mc_ext <= mc_ext << 1;
      mp_r   <= mp_r >> 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_busy(input int noise, input logic [N-1:0] a, input logic [N-1:0] b);
    case (noise)
      1: begin start = 1'b1; a_in = N'(3); b_in = N'(3); end
      2: begin start = 1'($urandom); a_in = N'($urandom); b_in = N'($urandom); end
      default: begin start = 1'b0; a_in = a; b_in = b; end
    endcase
  endtask

  // Entered at a negedge with the controller idle; leaves at the negedge after the ack edge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                        input int noise, input bit ack_high, output int e0);
    logic [31:0] exp_p;
    exp_p = 32'(a) * 32'(b);
    check_val("ready_before_start", 32'(ready), 1);
    a_in = a; b_in = b; start = 1'b1; ack = ack_high;
    @(posedge clock);
    e0 = int'($time / 10);
    #1 drive_busy(noise, a, b);
    @(negedge clock);
    check_val("init_do_init", 32'(do_init), 1);
    check_val("init_ready", 32'(ready), 0);
    check_val("init_do_shift", 32'(do_shift), 0);
    for (int k = 0; k < int'(N); k++) begin
      @(posedge clock);
      #1 drive_busy(noise, a, b);
      @(negedge clock);
      check_val("shift_do_shift", 32'(do_shift), 1);
      check_val("shift_do_init", 32'(do_init), 0);
      check_val("shift_done", 32'(done), 0);
      check_val("shift_ready", 32'(ready), 0);
      check_val("shift_multiplicand", 32'(multiplicand), 32'(a));
      check_val("shift_multiplier", 32'(multiplier), 32'(b));
    end
    @(posedge clock);
    #1 drive_busy(noise, a, b);
    @(negedge clock);
    check_val("done_latency", 32'(done), 1);
    check_val("done_do_shift", 32'(do_shift), 0);
    check_val("done_product", 32'(product), exp_p);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1 drive_busy(noise, a, b);
      @(negedge clock);
      check_val("hold_done", 32'(done), 1);
      check_val("hold_product", 32'(product), exp_p);
      check_val("hold_multiplicand", 32'(multiplicand), 32'(a));
    end
    ack = 1'b1;
    @(posedge clock);
    #1 begin start = 1'b0; ack = ack_high; a_in = a; b_in = b; end
    @(negedge clock);
    check_val("ack_ready", 32'(ready), 1);
    check_val("ack_done", 32'(done), 0);
    check_val("ack_no_init", 32'(do_init), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    logic [N-1:0] ra, rb;
    bit ackh;
    n_reset = 1'b0; start = 1'b0; ack = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("reset_ready", 32'(ready), 1);
    check_val("reset_do_init", 32'(do_init), 0);
    check_val("reset_do_shift", 32'(do_shift), 0);
    check_val("reset_done", 32'(done), 0);
    check_val("reset_multiplicand", 32'(multiplicand), 0);
    check_val("reset_multiplier", 32'(multiplier), 0);
    n_reset = 1'b1;
    @(negedge clock);

    run_op(N'(11), N'(6), 6, 0, 1'b0, e0);
    run_op(N'(11), N'(6), 2, 1, 1'b0, e0);
    repeat (3) begin
      @(negedge clock);
      check_val("idle_no_second_init", 32'(do_init), 0);
      check_val("idle_ready", 32'(ready), 1);
    end
    run_op(N'(15), N'(15), 0, 2, 1'b0, e0);

    // Abort during the second SHIFT cycle.
    a_in = N'(5); b_in = N'(5); start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check_val("abort_in_shift", 32'(do_shift), 1);
    n_reset = 1'b0;
    @(posedge clock);
    #1 n_reset = 1'b1;
    @(negedge clock);
    check_val("abort_ready", 32'(ready), 1);
    check_val("abort_do_shift", 32'(do_shift), 0);
    check_val("abort_done", 32'(done), 0);
    check_val("abort_multiplicand", 32'(multiplicand), 0);
    check_val("abort_multiplier", 32'(multiplier), 0);
    repeat (6) begin
      @(negedge clock);
      check_val("abort_no_done", 32'(done), 0);
    end
    run_op(N'(7), N'(9), 1, 0, 1'b0, e0);

    run_op(N'(0), N'(13), 0, 0, 1'b1, e0);
    run_op(N'(9), N'(1), 0, 0, 1'b1, e1);
    check_val("b2b_spacing", 32'(e1 - e0), 32'(N + 3));
    ack = 1'b0;

    repeat (20) begin
      ra   = N'($urandom);
      rb   = N'($urandom);
      ackh = 1'($urandom);
      run_op(ra, rb, ackh ? 0 : int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), ackh, e0);
      ack = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
